// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;

    localparam logic [1:0] BhtCtrReset = 2'b01;

    typedef enum logic [1:0] {
        ClsSeq,
        ClsBranch,
        ClsJal
    } fetch_cls_e;

    function automatic fetch_cls_e classify(input logic [6:0] opcode);
        if (opcode == OpBranch) begin
            return ClsBranch;
        end else if (opcode == OpJal) begin
            return ClsJal;
        end
        return ClsSeq;
    endfunction

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/fetch_stage_imm_gen.sv
// Combinational RV32I immediate extraction, selected by opcode.
module imm_gen
    import fetch_stage_pkg::*;
#(
    parameter int unsigned size = 32
) (
    input  logic [size-1:0] i_instr,
    output logic [size-1:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_instr[6:0])
            OpLoad, OpOpImm, OpJalr: begin
                o_imm = {{(size-12){i_instr[31]}}, i_instr[31:20]};
            end
            OpStore: begin
                o_imm = {{(size-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OpBranch: begin
                o_imm = {{(size-12){i_instr[31]}}, i_instr[7], i_instr[30:25],
                         i_instr[11:8], 1'b0};
            end
            OpLui, OpAuipc: begin
                o_imm = {{(size-32){i_instr[31]}}, i_instr[31:12], 12'b0};
            end
            OpJal: begin
                o_imm = {{(size-20){i_instr[31]}}, i_instr[19:12], i_instr[20],
                         i_instr[30:21], 1'b0};
            end
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a 2-bit-counter branch history table and IF/ID registers.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     size      = 32,
    parameter int unsigned     BHT_DEPTH = 16,
    parameter logic [size-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            buble,
    output logic [size-1:0] imem_addr,
    input  logic [size-1:0] imem_data,
    input  logic            redirect,
    input  logic [size-1:0] redirect_pc,
    input  logic            upd_en,
    input  logic [size-1:0] upd_pc,
    input  logic            upd_taken,
    output logic [size-1:0] instruction_o,
    output logic [size-1:0] IMM_o,
    output logic [size-1:0] PCplus_o,
    output logic            Predicted_MPC_o
);

    localparam int unsigned     IdxW   = $clog2(BHT_DEPTH);
    localparam logic [size-1:0] PcStep = size'(4);

    logic [size-1:0] r_pc;
    logic [1:0]      r_bht [BHT_DEPTH];

    logic [size-1:0] w_imm;
    logic [size-1:0] w_pc_plus;
    logic [size-1:0] w_next_pc;
    logic [IdxW-1:0] w_lookup_idx;
    logic [IdxW-1:0] w_upd_idx;
    fetch_cls_e      w_cls;
    logic            w_pred;
    logic            w_unused_upd;

    imm_gen #(
        .size(size)
    ) u_imm_gen (
        .i_instr(imem_data),
        .o_imm  (w_imm)
    );

    assign imem_addr    = r_pc;
    assign w_lookup_idx = r_pc[IdxW+1:2];
    assign w_upd_idx    = upd_pc[IdxW+1:2];
    assign w_unused_upd = ^{upd_pc[size-1:IdxW+2], upd_pc[1:0]};

    // Lookup reads the array before this edge's update, so a same-index hit sees the old value.
    always_comb begin
        w_cls     = classify(imem_data[6:0]);
        w_pred    = (w_cls == ClsJal) || ((w_cls == ClsBranch) && r_bht[w_lookup_idx][1]);
        w_pc_plus = r_pc + PcStep;
        w_next_pc = w_pred ? r_pc + w_imm : w_pc_plus;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc            <= RESET_PC;
            instruction_o   <= '0;
            IMM_o           <= '0;
            PCplus_o        <= '0;
            Predicted_MPC_o <= 1'b0;
        end else if (redirect) begin
            r_pc            <= redirect_pc;
            instruction_o   <= '0;
            IMM_o           <= '0;
            PCplus_o        <= '0;
            Predicted_MPC_o <= 1'b0;
        end else if (!buble) begin
            r_pc            <= w_next_pc;
            instruction_o   <= imem_data;
            IMM_o           <= w_imm;
            PCplus_o        <= w_pc_plus;
            Predicted_MPC_o <= w_pred;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= BhtCtrReset;
            end
        end else if (upd_en) begin
            r_bht[w_upd_idx] <= ctr_update(r_bht[w_upd_idx], upd_taken);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a model.
module tb_fetch_stage;

    localparam int Depth = 16;
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        buble;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] instruction_o;
    logic [31:0] IMM_o;
    logic [31:0] PCplus_o;
    logic        Predicted_MPC_o;

    // Model state
    logic [31:0] m_pc, m_instr, m_imm, m_pcp, cur_imm;
    logic        m_pred;
    int          m_bht [Depth];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .size     (32),
        .BHT_DEPTH(Depth),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .buble          (buble),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .instruction_o  (instruction_o),
        .IMM_o          (IMM_o),
        .PCplus_o       (PCplus_o),
        .Predicted_MPC_o(Predicted_MPC_o)
    );

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [11:0] v);
        return {v, 5'd3, 3'd0, 5'd4, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] v);
        return {v[11:5], 5'd5, 5'd6, 3'd2, v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] v);
        return {v[12], v[10:5], 5'd1, 5'd2, 3'd0, v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] v);
        return {v[20], v[10:1], v[11], v[19:12], 5'd0, 7'h6f};
    endfunction

    function automatic bit known_op(input logic [6:0] op);
        return op inside {7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h03, 7'h23, 7'h13};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = '0; m_imm = '0; m_pcp = '0; m_pred = 1'b0;
        for (int i = 0; i < Depth; i++) m_bht[i] = 1;
    endtask

    // Evaluated at the clock edge, using the inputs that were stable before it.
    task automatic model_edge();
        int  idx;
        int  uidx;
        bit  pred;
        idx  = int'((m_pc / 4) % Depth);
        pred = (imem_data[6:0] == 7'h6f) || (imem_data[6:0] == 7'h63 && m_bht[idx] >= 2);
        if (redirect) begin
            m_pc = redirect_pc; m_instr = '0; m_imm = '0; m_pcp = '0; m_pred = 1'b0;
        end else if (!buble) begin
            m_instr = imem_data; m_imm = cur_imm; m_pcp = m_pc + 4; m_pred = pred;
            m_pc = pred ? m_pc + cur_imm : m_pc + 4;
        end
        if (upd_en) begin
            uidx = int'((upd_pc / 4) % Depth);
            if (upd_taken) m_bht[uidx] = (m_bht[uidx] == 3) ? 3 : m_bht[uidx] + 1;
            else           m_bht[uidx] = (m_bht[uidx] == 0) ? 0 : m_bht[uidx] - 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] imm);
        imem_data = instr;
        cur_imm   = imm;
    endtask

    task automatic idle();
        buble = 0; redirect = 0; redirect_pc = '0; upd_en = 0; upd_pc = '0; upd_taken = 0;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        redirect = 1; redirect_pc = pc;
        step();
        redirect = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle();
        drive(enc_j(21'h40), 32'h40);
        redirect = 1; redirect_pc = 32'h200; buble = 1;
        upd_en = 1; upd_pc = 32'h40; upd_taken = 1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr);
        end
        n_checks++;
        if ({instruction_o, IMM_o, PCplus_o, Predicted_MPC_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h %h %h %b want 0", instruction_o, IMM_o,
                     PCplus_o, Predicted_MPC_o);
        end
        @(negedge clk);
        idle();
        reset = 1;
        model_reset();
    endtask

    task automatic test_sequential();
        drive(Nop, 32'h0);
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL seq_first_addr: got %h want 0", imem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (imem_addr !== 32'(4 * k)) begin
                n_fail++; $display("FAIL seq_addr: got %h want %h", imem_addr, 4 * k);
            end
            n_checks++;
            if (PCplus_o !== 32'(4 * k) || Predicted_MPC_o !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_pcplus: got %h/%b want %h/0", PCplus_o, Predicted_MPC_o, 4 * k);
            end
        end
    endtask

    task automatic test_jal();
        set_pc(32'h10);
        drive(32'h0200_006F, 32'h20);
        step();
        n_checks++;
        if (imem_addr !== 32'h30 || Predicted_MPC_o !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_target: got %h/%b want 30/1", imem_addr, Predicted_MPC_o);
        end
        n_checks++;
        if (IMM_o !== 32'h20 || instruction_o !== 32'h0200_006F || PCplus_o !== 32'h14) begin
            n_fail++;
            $display("FAIL jal_ifid: got %h %h %h want 20 0200006f 14", IMM_o, instruction_o,
                     PCplus_o);
        end
    endtask

    task automatic test_branch_predict();
        set_pc(32'h40);
        drive(enc_b(13'h1FF8), 32'hFFFF_FFF8);
        step();
        n_checks++;
        if (imem_addr !== 32'h44 || Predicted_MPC_o !== 1'b0) begin
            n_fail++;
            $display("FAIL br_weak_nt: got %h/%b want 44/0", imem_addr, Predicted_MPC_o);
        end
        upd_en = 1; upd_pc = 32'h40; upd_taken = 1;
        set_pc(32'h40);
        set_pc(32'h40);
        upd_en = 0;
        drive(enc_b(13'h1FF8), 32'hFFFF_FFF8);
        step();
        n_checks++;
        if (imem_addr !== 32'h38 || Predicted_MPC_o !== 1'b1) begin
            n_fail++;
            $display("FAIL br_taken: got %h/%b want 38/1", imem_addr, Predicted_MPC_o);
        end
        n_checks++;
        if (IMM_o !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL br_imm: got %h want fffffff8", IMM_o);
        end
    endtask

    task automatic test_same_index();
        set_pc(32'h84);
        drive(enc_b(13'h1FF8), 32'hFFFF_FFF8);
        upd_en = 1; upd_pc = 32'h84; upd_taken = 1;
        step();
        upd_en = 0;
        n_checks++;
        if (imem_addr !== 32'h88 || Predicted_MPC_o !== 1'b0) begin
            n_fail++;
            $display("FAIL same_idx_old: got %h/%b want 88/0", imem_addr, Predicted_MPC_o);
        end
        set_pc(32'h84);
        drive(enc_b(13'h1FF8), 32'hFFFF_FFF8);
        step();
        n_checks++;
        if (imem_addr !== 32'h7C || Predicted_MPC_o !== 1'b1) begin
            n_fail++;
            $display("FAIL same_idx_new: got %h/%b want 7c/1", imem_addr, Predicted_MPC_o);
        end
    endtask

    task automatic test_stall();
        set_pc(32'h0);
        drive(Nop, 32'h0);
        step();
        step();
        buble = 1;
        drive(enc_j(21'h80), 32'h80);
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (imem_addr !== 32'h8 || instruction_o !== Nop || PCplus_o !== 32'h8 ||
                IMM_o !== 32'h0 || Predicted_MPC_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: got %h %h %h %h %b want 8 13 8 0 0", imem_addr,
                         instruction_o, PCplus_o, IMM_o, Predicted_MPC_o);
            end
        end
        buble = 0;
        drive(Nop, 32'h0);
        step();
        n_checks++;
        if (imem_addr !== 32'hC || PCplus_o !== 32'hC) begin
            n_fail++; $display("FAIL stall_resume: got %h/%h want c/c", imem_addr, PCplus_o);
        end
    endtask

    task automatic test_redirect_priority();
        drive(enc_j(21'h40), 32'h40);
        buble = 1; redirect = 1; redirect_pc = 32'h100;
        step();
        buble = 0; redirect = 0;
        n_checks++;
        if (imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL redir_addr: got %h want 100", imem_addr);
        end
        n_checks++;
        if ({instruction_o, IMM_o, PCplus_o, Predicted_MPC_o} !== '0) begin
            n_fail++;
            $display("FAIL redir_flush: got %h %h %h %b want 0", instruction_o, IMM_o,
                     PCplus_o, Predicted_MPC_o);
        end
    endtask

    task automatic test_async_reset();
        set_pc(32'h20);
        drive(Nop, 32'h0);
        step();
        n_checks++;
        if (imem_addr !== 32'h24 || PCplus_o !== 32'h24) begin
            n_fail++; $display("FAIL pre_rst: got %h/%h want 24/24", imem_addr, PCplus_o);
        end
        #2;
        reset = 0;
        #1;
        n_checks++;
        if (imem_addr !== 32'h0 || {instruction_o, IMM_o, PCplus_o, Predicted_MPC_o} !== '0) begin
            n_fail++;
            $display("FAIL async_rst: got %h %h %h %h %b want 0", imem_addr, instruction_o,
                     IMM_o, PCplus_o, Predicted_MPC_o);
        end
        @(negedge clk);
        reset = 1;
        model_reset();
        // Counter at 0x40 was saturated before reset; it must be weakly not-taken again.
        set_pc(32'h40);
        drive(enc_b(13'h1FF8), 32'hFFFF_FFF8);
        step();
        n_checks++;
        if (imem_addr !== 32'h44 || Predicted_MPC_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ctr: got %h/%b want 44/0", imem_addr, Predicted_MPC_o);
        end
    endtask

    task automatic gen_rand(output logic [31:0] instr, output logic [31:0] imm);
        int          s;
        logic [31:0] sv;
        logic [6:0]  op;
        case ($urandom_range(0, 9))
            0, 1: begin
                s = $urandom_range(0, 4095) - 2048; sv = 32'(s);
                case ($urandom_range(0, 2))
                    0: op = 7'h03;
                    1: op = 7'h13;
                    default: op = 7'h67;
                endcase
                instr = enc_i(op, sv[11:0]); imm = sv;
            end
            2: begin
                s = $urandom_range(0, 4095) - 2048; sv = 32'(s);
                instr = enc_s(sv[11:0]); imm = sv;
            end
            3, 4, 5: begin
                s = 2 * ($urandom_range(0, 4095) - 2048); sv = 32'(s);
                instr = enc_b(sv[12:0]); imm = sv;
            end
            6: begin
                s = 2 * ($urandom_range(0, 1048575) - 524288); sv = 32'(s);
                instr = enc_j(sv[20:0]); imm = sv;
            end
            7: begin
                sv = $urandom & 32'hFFFF_F000;
                op = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
                instr = {sv[31:12], 5'd7, op}; imm = sv;
            end
            default: begin
                do op = 7'($urandom_range(0, 127)); while (known_op(op));
                sv = $urandom;
                instr = {sv[31:7], op}; imm = 32'h0;
            end
        endcase
    endtask

    task automatic test_random();
        logic [31:0] instr, imm;
        for (int n = 0; n < 400; n++) begin
            gen_rand(instr, imm);
            drive(instr, imm);
            buble       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = 32'($urandom_range(0, 1023)) * 4;
            upd_en      = ($urandom_range(0, 9) < 4);
            upd_pc      = ($urandom_range(0, 3) == 0) ? m_pc : 32'($urandom_range(0, 63)) * 4;
            upd_taken   = ($urandom_range(0, 2) != 0);
            step();
            n_checks++;
            if (imem_addr !== m_pc) begin
                n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, imem_addr, m_pc);
            end
            n_checks++;
            if (instruction_o !== m_instr || IMM_o !== m_imm) begin
                n_fail++;
                $display("FAIL rnd_instr_imm[%0d]: got %h/%h want %h/%h", n, instruction_o,
                         IMM_o, m_instr, m_imm);
            end
            n_checks++;
            if (PCplus_o !== m_pcp || Predicted_MPC_o !== m_pred) begin
                n_fail++;
                $display("FAIL rnd_pcp_pred[%0d]: got %h/%b want %h/%b", n, PCplus_o,
                         Predicted_MPC_o, m_pcp, m_pred);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        cur_imm   = '0;
        imem_data = Nop;
        test_reset();
        test_sequential();
        test_jal();
        test_branch_predict();
        test_same_index();
        test_stall();
        test_redirect_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
